// File: rtl/lenet_load_ctrl.sv
// -----------------------------------------------------------------------------
// lenet_load_ctrl
// Sequencer between the register-write stream and the LeNet inference core.
// Register writes for weights, bias and input feature map are turned into
// addressed RAM writes. Once all buffers are full and enable is set, a single
// start pulse is issued. The core's done/result are then captured into sticky
// status outputs, and a new fmap write after completion starts the next image.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   soft_reset          level, same effect as reset while high
//   ce                  enable (gates start and core clock enable)
//   wr_valid/sel/data   incoming register write (sel 1=wt, 2=bias, 3=fmap)
//   wr_ready            write accepted when wr_valid && wr_ready
//   wt_*/bs_*/fm_*      registered RAM write ports (1-cycle latency)
//   core_start          one-cycle start pulse
//   core_ce             core clock enable (ce while running)
//   core_done/result    completion pulse and classified digit from the core
//   end_flag, result    sticky completion flag and captured digit
//   err_ovf             sticky overflow / illegal-write flag
//   state_o             debug state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
// -----------------------------------------------------------------------------
module lenet_load_ctrl #(
  parameter int N_WEIGHT = 3220,
  parameter int N_BIAS   = 10,
  parameter int N_FMAP   = 784,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          soft_reset,
  input  logic          ce,
  input  logic          wr_valid,
  input  logic [1:0]    wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  output logic          wt_we,
  output logic [11:0]   wt_addr,
  output logic [DW-1:0] wt_wdata,
  output logic          bs_we,
  output logic [3:0]    bs_addr,
  output logic [DW-1:0] bs_wdata,
  output logic          fm_we,
  output logic [9:0]    fm_addr,
  output logic [DW-1:0] fm_wdata,
  output logic          core_start,
  output logic          core_ce,
  input  logic          core_done,
  input  logic [3:0]    core_result,
  output logic          end_flag,
  output logic [3:0]    result,
  output logic          err_ovf,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [11:0] WT_FULL = 12'(N_WEIGHT);
  localparam logic [3:0]  BS_FULL = 4'(N_BIAS);
  localparam logic [9:0]  FM_FULL = 10'(N_FMAP);

  state_t          state_q, state_d;
  logic [11:0]     wt_cnt_q, wt_cnt_d;
  logic [3:0]      bs_cnt_q, bs_cnt_d;
  logic [9:0]      fm_cnt_q, fm_cnt_d;
  logic            wt_we_q, wt_we_d;
  logic [11:0]     wt_addr_q, wt_addr_d;
  logic [DW-1:0]   wt_wdata_q, wt_wdata_d;
  logic            bs_we_q, bs_we_d;
  logic [3:0]      bs_addr_q, bs_addr_d;
  logic [DW-1:0]   bs_wdata_q, bs_wdata_d;
  logic            fm_we_q, fm_we_d;
  logic [9:0]      fm_addr_q, fm_addr_d;
  logic [DW-1:0]   fm_wdata_q, fm_wdata_d;
  logic            core_start_q, core_start_d;
  logic            end_flag_q, end_flag_d;
  logic [3:0]      result_q, result_d;
  logic            err_ovf_q, err_ovf_d;

  logic            accept_s;
  logic            restart_s;
  logic [9:0]      fm_base_s;

  // The core is never handed a write while it is running.
  assign wr_ready = (state_q != S_RUN);

  // Next-state, counter and RAM-port computation.
  always_comb begin
    state_d      = state_q;
    wt_cnt_d     = wt_cnt_q;
    bs_cnt_d     = bs_cnt_q;
    fm_cnt_d     = fm_cnt_q;
    wt_we_d      = 1'b0;
    wt_addr_d    = wt_addr_q;
    wt_wdata_d   = wt_wdata_q;
    bs_we_d      = 1'b0;
    bs_addr_d    = bs_addr_q;
    bs_wdata_d   = bs_wdata_q;
    fm_we_d      = 1'b0;
    fm_addr_d    = fm_addr_q;
    fm_wdata_d   = fm_wdata_q;
    core_start_d = 1'b0;
    end_flag_d   = end_flag_q;
    result_d     = result_q;
    err_ovf_d    = err_ovf_q;

    accept_s  = wr_valid && wr_ready;
    // First fmap write after completion begins a new image at address 0.
    restart_s = accept_s && (state_q == S_DONE) && (wr_sel == 2'd3);
    fm_base_s = restart_s ? 10'd0 : fm_cnt_q;

    if (accept_s) begin
      case (wr_sel)
        2'd1: begin
          // Weights are frozen after completion; a write there is illegal.
          if ((state_q != S_DONE) && (wt_cnt_q != WT_FULL)) begin
            wt_we_d    = 1'b1;
            wt_addr_d  = wt_cnt_q;
            wt_wdata_d = wr_data;
            wt_cnt_d   = wt_cnt_q + 12'd1;
          end else begin
            err_ovf_d  = 1'b1;
          end
        end
        2'd2: begin
          if ((state_q != S_DONE) && (bs_cnt_q != BS_FULL)) begin
            bs_we_d    = 1'b1;
            bs_addr_d  = bs_cnt_q;
            bs_wdata_d = wr_data;
            bs_cnt_d   = bs_cnt_q + 4'd1;
          end else begin
            err_ovf_d  = 1'b1;
          end
        end
        2'd3: begin
          if (fm_base_s != FM_FULL) begin
            fm_we_d    = 1'b1;
            fm_addr_d  = fm_base_s;
            fm_wdata_d = wr_data;
            fm_cnt_d   = fm_base_s + 10'd1;
          end else begin
            err_ovf_d  = 1'b1;
          end
        end
        default: err_ovf_d = 1'b1;
      endcase
    end else begin
      err_ovf_d = err_ovf_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ce) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // Post-write counts are used so the last write and the start share an edge.
        if (ce && (wt_cnt_d == WT_FULL) && (bs_cnt_d == BS_FULL) && (fm_cnt_d == FM_FULL)) begin
          state_d      = S_RUN;
          core_start_d = 1'b1;
        end else begin
          state_d      = S_LOAD;
        end
      end
      S_RUN: begin
        if (core_done) begin
          state_d    = S_DONE;
          result_d   = core_result;
          end_flag_d = 1'b1;
        end else begin
          state_d    = S_RUN;
        end
      end
      S_DONE: begin
        if (restart_s) begin
          state_d    = S_LOAD;
          end_flag_d = 1'b0;
        end else begin
          state_d    = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output flops; soft_reset behaves as reset.
  always_ff @(posedge clk) begin
    if (reset || soft_reset) begin
      state_q      <= S_IDLE;
      wt_cnt_q     <= 12'd0;
      bs_cnt_q     <= 4'd0;
      fm_cnt_q     <= 10'd0;
      wt_we_q      <= 1'b0;
      wt_addr_q    <= 12'd0;
      wt_wdata_q   <= '0;
      bs_we_q      <= 1'b0;
      bs_addr_q    <= 4'd0;
      bs_wdata_q   <= '0;
      fm_we_q      <= 1'b0;
      fm_addr_q    <= 10'd0;
      fm_wdata_q   <= '0;
      core_start_q <= 1'b0;
      end_flag_q   <= 1'b0;
      result_q     <= 4'd0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wt_cnt_q     <= wt_cnt_d;
      bs_cnt_q     <= bs_cnt_d;
      fm_cnt_q     <= fm_cnt_d;
      wt_we_q      <= wt_we_d;
      wt_addr_q    <= wt_addr_d;
      wt_wdata_q   <= wt_wdata_d;
      bs_we_q      <= bs_we_d;
      bs_addr_q    <= bs_addr_d;
      bs_wdata_q   <= bs_wdata_d;
      fm_we_q      <= fm_we_d;
      fm_addr_q    <= fm_addr_d;
      fm_wdata_q   <= fm_wdata_d;
      core_start_q <= core_start_d;
      end_flag_q   <= end_flag_d;
      result_q     <= result_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign wt_we      = wt_we_q;
  assign wt_addr    = wt_addr_q;
  assign wt_wdata   = wt_wdata_q;
  assign bs_we      = bs_we_q;
  assign bs_addr    = bs_addr_q;
  assign bs_wdata   = bs_wdata_q;
  assign fm_we      = fm_we_q;
  assign fm_addr    = fm_addr_q;
  assign fm_wdata   = fm_wdata_q;
  assign core_start = core_start_q;
  // The core only advances while running and enabled; dropping ce stalls it.
  assign core_ce    = (state_q == S_RUN) && ce;
  assign end_flag   = end_flag_q;
  assign result     = result_q;
  assign err_ovf    = err_ovf_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_lenet_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lenet_load_ctrl
// Directed bench for lenet_load_ctrl. A behavioural model (integer counters,
// phase variable) predicts every output each cycle; a negedge process compares
// DUT against it, and hand-computed literal checks pin key scenario points.
// -----------------------------------------------------------------------------
module tb_lenet_load_ctrl;

  localparam int NW = 3220;
  localparam int NB = 10;
  localparam int NF = 784;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        soft_reset = 1'b0;
  logic        ce = 1'b0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_sel = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic        wt_we, bs_we, fm_we;
  logic [11:0] wt_addr;
  logic [3:0]  bs_addr;
  logic [9:0]  fm_addr;
  logic [31:0] wt_wdata, bs_wdata, fm_wdata;
  logic        core_start, core_ce;
  logic        core_done = 1'b0;
  logic [3:0]  core_result = 4'd0;
  logic        end_flag, err_ovf;
  logic [3:0]  result;
  logic [1:0]  state_o;

  lenet_load_ctrl dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .ce(ce),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ready(wr_ready),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_wdata(wt_wdata),
    .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_wdata(fm_wdata),
    .core_start(core_start), .core_ce(core_ce),
    .core_done(core_done), .core_result(core_result),
    .end_flag(end_flag), .result(result), .err_ovf(err_ovf), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 load, 2 run, 3 done
  int m_phase = 0, m_wt = 0, m_bs = 0, m_fm = 0;
  int m_end = 0, m_res = 0, m_ovf = 0;
  int e_start = 0;
  int e_wt_we = 0, e_wt_addr = 0; logic [31:0] e_wt_data = 0;
  int e_bs_we = 0, e_bs_addr = 0; logic [31:0] e_bs_data = 0;
  int e_fm_we = 0, e_fm_addr = 0; logic [31:0] e_fm_data = 0;

  always @(posedge clk) begin
    int old;
    bit acc;
    if (reset || soft_reset) begin
      m_phase = 0; m_wt = 0; m_bs = 0; m_fm = 0;
      m_end = 0; m_res = 0; m_ovf = 0; e_start = 0;
      e_wt_we = 0; e_bs_we = 0; e_fm_we = 0;
    end else begin
      old = m_phase;
      e_wt_we = 0; e_bs_we = 0; e_fm_we = 0; e_start = 0;
      acc = wr_valid && (old != 2);
      if (acc) begin
        if (wr_sel == 2'd1 && old != 3 && m_wt < NW) begin
          e_wt_we = 1; e_wt_addr = m_wt; e_wt_data = wr_data; m_wt++;
        end else if (wr_sel == 2'd2 && old != 3 && m_bs < NB) begin
          e_bs_we = 1; e_bs_addr = m_bs; e_bs_data = wr_data; m_bs++;
        end else if (wr_sel == 2'd3 && old == 3) begin
          // new image: fmap buffer restarts, weights/bias kept
          e_fm_we = 1; e_fm_addr = 0; e_fm_data = wr_data; m_fm = 1;
          m_end = 0; m_phase = 1;
        end else if (wr_sel == 2'd3 && m_fm < NF) begin
          e_fm_we = 1; e_fm_addr = m_fm; e_fm_data = wr_data; m_fm++;
        end else begin
          m_ovf = 1;
        end
      end
      if (old == 0 && ce) m_phase = 1;
      else if (old == 1 && ce && m_wt == NW && m_bs == NB && m_fm == NF) begin
        m_phase = 2; e_start = 1;
      end else if (old == 2 && core_done) begin
        m_phase = 3; m_end = 1; m_res = core_result;
      end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int n_start = 0;
  int last_wt = -1, last_bs = -1, last_fm = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",      state_o,    m_phase);
      chk("wr_ready",   wr_ready,   (m_phase != 2));
      chk("core_ce",    core_ce,    (m_phase == 2) && ce);
      chk("core_start", core_start, e_start);
      chk("end_flag",   end_flag,   m_end);
      chk("result",     result,     m_res);
      chk("err_ovf",    err_ovf,    m_ovf);
      chk("wt_we",      wt_we,      e_wt_we);
      chk("bs_we",      bs_we,      e_bs_we);
      chk("fm_we",      fm_we,      e_fm_we);
      if (e_wt_we != 0) begin
        chk("wt_addr", wt_addr, e_wt_addr); chk("wt_wdata", wt_wdata, e_wt_data);
      end
      if (e_bs_we != 0) begin
        chk("bs_addr", bs_addr, e_bs_addr); chk("bs_wdata", bs_wdata, e_bs_data);
      end
      if (e_fm_we != 0) begin
        chk("fm_addr", fm_addr, e_fm_addr); chk("fm_wdata", fm_wdata, e_fm_data);
      end
      if (core_start) n_start++;
      if (wt_we) last_wt = int'(wt_addr);
      if (bs_we) last_bs = int'(bs_addr);
      if (fm_we) last_fm = int'(fm_addr);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic burst(input logic [1:0] sel, input int n, input logic [31:0] base);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_sel  = sel;
      wr_data = base + 32'(i);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic full_load();
    burst(2'd1, NW, 32'h1000_0000);
    burst(2'd2, NB, 32'h2000_0000);
    burst(2'd3, NF, 32'h3000_0000);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0;
  endtask

  initial begin
    tick(2);
    chk_en = 1'b1;
    // reset state
    chk("rst_state", state_o, 0);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset = 1'b0;

    // full load with ce=1; last fmap write commits with core_start in same cycle
    ce = 1'b1;
    full_load();
    chk("lit_start_now", core_start, 1);
    chk("lit_fm_last", fm_addr, 783);
    chk("lit_state_run", state_o, 2);
    chk("lit_last_wt", last_wt, 3219);
    chk("lit_last_bs", last_bs, 9);
    tick(1);
    chk("lit_start_once", n_start, 1);
    chk("lit_ready_run", wr_ready, 0);

    // completion
    tick(3);
    core_done = 1'b1; core_result = 4'd4;
    tick(1);
    core_done = 1'b0; core_result = 4'd0;
    chk("lit_end", end_flag, 1);
    chk("lit_result", result, 4);
    chk("lit_state_done", state_o, 3);

    // second image: first fmap write restarts at address 0
    burst(2'd3, 1, 32'h0000_ABCD);
    chk("lit_fm_re_we", fm_we, 1);
    chk("lit_fm_re_addr", fm_addr, 0);
    chk("lit_fm_re_data", fm_wdata, 32'h0000_ABCD);
    chk("lit_end_clr", end_flag, 0);
    chk("lit_state_load", state_o, 1);
    // 3221st weight write overflows
    burst(2'd1, 1, 32'hDEAD_BEEF);
    chk("lit_ovf_no_we", wt_we, 0);
    chk("lit_ovf", err_ovf, 1);
    burst(2'd3, NF - 1, 32'h4000_0001);
    chk("lit_start2", core_start, 1);
    tick(1);
    chk("lit_start_twice", n_start, 2);
    core_done = 1'b1; core_result = 4'd7;
    tick(1);
    core_done = 1'b0;
    chk("lit_result2", result, 7);

    // sel=0 write flags overflow
    do_reset();
    chk("lit_ovf_cleared", err_ovf, 0);
    ce = 1'b0;
    burst(2'd0, 1, 32'h5);
    chk("lit_ovf_sel0", err_ovf, 1);

    // ce gating: preload in IDLE, no start
    full_load();
    tick(3);
    chk("lit_gate_idle", state_o, 0);
    chk("lit_gate_nostart", n_start, 2);
    ce = 1'b1;
    tick(1);
    chk("lit_gate_load", state_o, 1);
    tick(1);
    chk("lit_gate_run", state_o, 2);
    chk("lit_gate_start", core_start, 1);
    ce = 1'b0;
    tick(3);
    chk("lit_stall_ce", core_ce, 0);
    chk("lit_stall_run", state_o, 2);
    ce = 1'b1;
    tick(1);
    chk("lit_ce_back", core_ce, 1);

    // soft reset mid-run, core_done in the reset cycle is discarded
    soft_reset = 1'b1; core_done = 1'b1; core_result = 4'd9;
    tick(1);
    soft_reset = 1'b0; core_done = 1'b0;
    chk("lit_srst_state", state_o, 0);
    chk("lit_srst_end", end_flag, 0);
    chk("lit_srst_ovf", err_ovf, 0);
    chk("lit_srst_res", result, 0);
    chk("lit_srst_start", core_start, 0);
    core_done = 1'b1; core_result = 4'd3;
    tick(1);
    core_done = 1'b0;
    tick(2);
    chk("lit_late_done", end_flag, 0);
    // counters were cleared: one weight write lands at address 0
    burst(2'd1, 1, 32'h77);
    chk("lit_cnt_clr", wt_addr, 0);
    chk("lit_cnt_we", wt_we, 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
